// File: rtl/sine_lut_sequencer.sv
// Address sequencer for the registered half-sine table feeding the SSPWM comparator.
// Walks one half period per polarity and re-presents each captured sample as magnitude and signed value.
module sine_lut_sequencer #(
  parameter int HALF_STEPS = 88,
  parameter int MIN_DIV    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] step_div,
  output logic [6:0]  lut_addr,
  input  logic [12:0] lut_data,
  output logic [12:0] sample,
  output logic [13:0] sample_signed,
  output logic        polarity,
  output logic        sample_valid,
  output logic        cycle_start
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // Step length in cycles; below MIN_DIV the ISSUE/CAPTURE pipeline could not keep up.
  function automatic logic [15:0] eff_div_f(input logic [15:0] div);
    logic [15:0] min_div;
    min_div = 16'(MIN_DIV);
    return (div < min_div) ? min_div : div;
  endfunction

  function automatic logic [13:0] apply_sign_f(input logic [12:0] mag, input logic neg);
    logic [13:0] wide;
    wide = {1'b0, mag};
    return neg ? (14'd0 - wide) : wide;
  endfunction

  state_t      state_r, state_s;
  logic [6:0]  idx_r, idx_s;
  logic        polarity_r, polarity_s;
  logic [15:0] timer_r, timer_s;
  logic [12:0] sample_r, sample_s;
  logic [13:0] sample_signed_r, sample_signed_s;
  logic        sample_valid_r, sample_valid_s;
  logic        cycle_start_r, cycle_start_s;
  logic [15:0] reload_s;

  assign reload_s = eff_div_f(step_div) - 16'd1;

  // Next-state and next-output logic; a low enable overrides everything and returns to the idle values.
  always_comb begin
    state_s         = state_r;
    idx_s           = idx_r;
    polarity_s      = polarity_r;
    timer_s         = (timer_r != 16'd0) ? (timer_r - 16'd1) : 16'd0;
    sample_s        = sample_r;
    sample_signed_s = sample_signed_r;
    sample_valid_s  = 1'b0;
    cycle_start_s   = 1'b0;

    if (!enable) begin
      state_s         = IDLE;
      idx_s           = 7'd0;
      polarity_s      = 1'b0;
      timer_s         = 16'd0;
      sample_s        = 13'd0;
      sample_signed_s = 14'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_s    = ISSUE;
          idx_s      = 7'd0;
          polarity_s = 1'b0;
          timer_s    = reload_s;
        end
        ISSUE: begin
          state_s = CAPTURE;
        end
        CAPTURE: begin
          state_s         = HOLD;
          sample_s        = lut_data;
          sample_signed_s = apply_sign_f(lut_data, polarity_r);
          sample_valid_s  = 1'b1;
          cycle_start_s   = (idx_r == 7'd0) && !polarity_r;
        end
        HOLD: begin
          if (timer_r == 16'd0) begin
            state_s = ISSUE;
            timer_s = reload_s;
            // Address HALF_STEPS would repeat the zero at address 0, so wrap before it.
            if (idx_r == 7'(HALF_STEPS - 1)) begin
              idx_s      = 7'd0;
              polarity_s = !polarity_r;
            end else begin
              idx_s      = idx_r + 7'd1;
            end
          end else begin
            state_s = HOLD;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      idx_r           <= 7'd0;
      polarity_r      <= 1'b0;
      timer_r         <= 16'd0;
      sample_r        <= 13'd0;
      sample_signed_r <= 14'd0;
      sample_valid_r  <= 1'b0;
      cycle_start_r   <= 1'b0;
    end else begin
      state_r         <= state_s;
      idx_r           <= idx_s;
      polarity_r      <= polarity_s;
      timer_r         <= timer_s;
      sample_r        <= sample_s;
      sample_signed_r <= sample_signed_s;
      sample_valid_r  <= sample_valid_s;
      cycle_start_r   <= cycle_start_s;
    end
  end

  assign lut_addr      = idx_r;
  assign polarity      = polarity_r;
  assign sample        = sample_r;
  assign sample_signed = sample_signed_r;
  assign sample_valid  = sample_valid_r;
  assign cycle_start   = cycle_start_r;

endmodule

// File: tb/tb_sine_lut_sequencer.sv
// Directed bench for sine_lut_sequencer with a registered half-sine table model.
module tb_sine_lut_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] step_div;
  logic [6:0]  lut_addr;
  logic [12:0] lut_data;
  logic [12:0] sample;
  logic [13:0] sample_signed;
  logic        polarity;
  logic        sample_valid;
  logic        cycle_start;

  int checks = 0;
  int errors = 0;
  logic [12:0] lut_rom [0:127];
  int early_vals [3] = '{178, 357, 534};

  sine_lut_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .step_div      (step_div),
    .lut_addr      (lut_addr),
    .lut_data      (lut_data),
    .sample        (sample),
    .sample_signed (sample_signed),
    .polarity      (polarity),
    .sample_valid  (sample_valid),
    .cycle_start   (cycle_start)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 128; i++) begin
      if (i < 88) lut_rom[i] = 13'($rtoi(5000.0 * $sin(3.14159265358979 * i / 88.0) + 0.5));
      else        lut_rom[i] = 13'd0;
    end
  end

  // Table model: one cycle of read latency.
  always_ff @(posedge clk) lut_data <= lut_rom[lut_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_addr"}, 32'(lut_addr), 32'd0);
    check({tag, "_outs"}, 32'({sample, sample_signed, polarity, sample_valid, cycle_start}), 32'd0);
  endtask

  // Counts negedges until the next sample_valid, bounded.
  task automatic wait_pulse(input int max_cycles, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_valid && n < max_cycles);
    check("pulse_seen", 32'(sample_valid), 32'd1);
  endtask

  initial begin
    int n;
    logic [13:0] neg178;
    logic [13:0] neg357;
    neg178 = 14'd0 - 14'd178;
    neg357 = 14'd0 - 14'd357;

    rst_n = 1'b0; enable = 1'b0; step_div = 16'd4;
    repeat (3) @(negedge clk);
    check_idle("in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle("idle");
    end

    // Start-up and steady stepping at step_div 4
    enable = 1'b1;
    wait_pulse(20, n);
    check("start_latency", 32'(n), 32'd3);
    check("first_sample", 32'(sample), 32'd0);
    check("first_cstart", 32'(cycle_start), 32'd1);
    check("first_pol", 32'(polarity), 32'd0);
    for (int s = 1; s <= 3; s++) begin
      wait_pulse(20, n);
      check("interval4", 32'(n), 32'd4);
      check("early_sample", 32'(sample), 32'(early_vals[s-1]));
      check("early_signed", 32'(sample_signed), 32'(early_vals[s-1]));
      check("early_cstart", 32'(cycle_start), 32'd0);
    end
    @(negedge clk);
    check("valid_one_cycle", 32'(sample_valid), 32'd0);
    check("sample_stable", 32'(sample), 32'd534);
    for (int s = 4; s <= 44; s++) begin
      wait_pulse(20, n);
      check("step_interval", 32'(n), (s == 4) ? 32'd3 : 32'd4);
    end
    check("peak_sample", 32'(sample), 32'd5000);
    check("peak_addr", 32'(lut_addr), 32'd44);
    for (int s = 45; s <= 87; s++) begin
      wait_pulse(20, n);
      check("step_interval", 32'(n), 32'd4);
      check("pos_pol", 32'(polarity), 32'd0);
    end
    check("last_pos_sample", 32'(sample), 32'd178);

    // Half-cycle wrap: polarity flips when address 0 is issued
    @(negedge clk);
    check("pre_wrap_pol", 32'(polarity), 32'd0);
    check("pre_wrap_addr", 32'(lut_addr), 32'd87);
    @(negedge clk);
    check("wrap_pol", 32'(polarity), 32'd1);
    check("wrap_addr", 32'(lut_addr), 32'd0);
    check("wrap_old_sample", 32'(sample), 32'd178);
    wait_pulse(20, n);
    check("wrap_interval", 32'(n), 32'd2);
    check("neg0_sample", 32'(sample), 32'd0);
    check("neg0_signed", 32'(sample_signed), 32'd0);
    check("neg0_cstart", 32'(cycle_start), 32'd0);
    wait_pulse(20, n);
    check("neg1_interval", 32'(n), 32'd4);
    check("neg1_sample", 32'(sample), 32'd178);
    check("neg1_signed", 32'(sample_signed), 32'(neg178));
    wait_pulse(20, n);
    check("neg2_signed", 32'(sample_signed), 32'(neg357));
    for (int s = 91; s <= 175; s++) begin
      wait_pulse(20, n);
      check("step_interval", 32'(n), 32'd4);
      check("neg_cstart", 32'(cycle_start), 32'd0);
      check("neg_pol", 32'(polarity), 32'd1);
    end
    wait_pulse(20, n);
    check("period_cstart", 32'(cycle_start), 32'd1);
    check("period_pol", 32'(polarity), 32'd0);
    check("period_sample", 32'(sample), 32'd0);

    // Clamp of small dividers and reload-only divider changes
    enable = 1'b0;
    @(negedge clk);
    check_idle("disabled");
    step_div = 16'd1;
    enable = 1'b1;
    wait_pulse(20, n);
    check("restart_latency", 32'(n), 32'd3);
    for (int i = 0; i < 3; i++) begin
      wait_pulse(20, n);
      check("clamp_div1", 32'(n), 32'd3);
    end
    step_div = 16'd0;
    for (int i = 0; i < 3; i++) begin
      wait_pulse(20, n);
      check("clamp_div0", 32'(n), 32'd3);
    end
    step_div = 16'd3;
    wait_pulse(20, n);
    check("div3", 32'(n), 32'd3);
    step_div = 16'd10;
    wait_pulse(20, n);
    check("div10_pending", 32'(n), 32'd3);
    wait_pulse(20, n);
    check("div10_active", 32'(n), 32'd10);
    step_div = 16'd4;
    wait_pulse(20, n);
    check("div4_pending", 32'(n), 32'd10);
    wait_pulse(20, n);
    check("div4_active", 32'(n), 32'd4);

    // Disable while in CAPTURE
    repeat (3) @(negedge clk);
    check("pre_disable_valid", 32'(sample_valid), 32'd0);
    enable = 1'b0;
    @(negedge clk);
    check_idle("disable_capture");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_pulse_after_disable", 32'(sample_valid), 32'd0);
    end
    enable = 1'b1;
    wait_pulse(20, n);
    check("reenable_latency", 32'(n), 32'd3);
    check("reenable_sample", 32'(sample), 32'd0);
    check("reenable_cstart", 32'(cycle_start), 32'd1);
    check("reenable_addr", 32'(lut_addr), 32'd0);

    // Disable on the same edge the timer expires: no ISSUE for address 3
    for (int i = 0; i < 2; i++) begin
      wait_pulse(20, n);
      check("pre_expiry_interval", 32'(n), 32'd4);
    end
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("disable_beats_expiry", 32'(lut_addr), 32'd0);
    check_idle("expiry_disabled");

    // Asynchronous reset between edges during HOLD at address 30
    enable = 1'b1;
    wait_pulse(20, n);
    check("run_latency", 32'(n), 32'd3);
    for (int i = 1; i <= 30; i++) wait_pulse(20, n);
    check("addr30", 32'(lut_addr), 32'd30);
    #1 rst_n = 1'b0;
    #1 check_idle("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    wait_pulse(20, n);
    check("post_reset_latency", 32'(n), 32'd3);
    check("post_reset_sample", 32'(sample), 32'd0);
    check("post_reset_cstart", 32'(cycle_start), 32'd1);
    wait_pulse(20, n);
    check("post_reset_interval", 32'(n), 32'd4);
    check("post_reset_sample1", 32'(sample), 32'd178);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
